instruction_memory: RTL and testbench

Synchronous memory responder serving the CPU instruction-fetch handshake (mem_address / mem_read / mem_value / mem_ready). It sits opposite the CPU fetch unit and answers each read request after a programmable latency. It replaces the behavioural memory emulator in benches and is the synthesizable instruction store for the no-op CPU. Default contents are NOOP up to a configurable address and HALT beyond it.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instruction_memory_mem_array.sv | 38 +++
 rtl/instruction_memory.sv | 132 +++++++++++++
 tb/tb_instruction_memory.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Types and constants shared by the no-op CPU fetch unit and the instruction store.
package cpu_pkg;

    localparam int ARCH_SIZE = 31;

    localparam int unsigned NOOP = 0;
    localparam int unsigned HALT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } mem_state_t;

    // Power-on contents: NOOP up to and including the byte address noop_limit, HALT above.
    function automatic int unsigned default_word(input int index, input int noop_limit);
        return (2 * index <= noop_limit) ? NOOP : HALT;
    endfunction

endpackage

// File: rtl/instruction_memory_mem_array.sv
// DEPTH x WIDTH instruction storage, reloaded with the NOOP/HALT image on every reset.
// The write port exists only when INSTRUCTION_MEMORY_WRITE_EN is defined.
module mem_array #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 32,
    parameter int NOOP_LIMIT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] read_index,
    output logic [WIDTH-1:0]         read_data
`ifdef INSTRUCTION_MEMORY_WRITE_EN
    ,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_index,
    input  logic [WIDTH-1:0]         write_data
`endif
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] words [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= WIDTH'(default_word(i, NOOP_LIMIT));
            end
        end
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        else if (write_en) begin
            words[write_index] <= write_data;
        end
`endif
    end

    assign read_data = words[read_index];

endmodule

// File: rtl/instruction_memory.sv
// Instruction store answering the CPU fetch four-phase handshake after LATENCY cycles.
// Optional write requests are enabled by defining INSTRUCTION_MEMORY_WRITE_EN.
//
// state | meaning
// IDLE  | waiting for mem_read; address (and write payload) latched on acceptance
// WAIT  | latency countdown; mem_read dropping here aborts silently
// READY | response held until mem_read drops
module instruction_memory #(
    parameter int ARCH_SIZE  = cpu_pkg::ARCH_SIZE,
    parameter int DEPTH      = 32,
    parameter int LATENCY    = 2,
    parameter int NOOP_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ARCH_SIZE:0] mem_address,
    input  logic             mem_read,
`ifdef INSTRUCTION_MEMORY_WRITE_EN
    input  logic             mem_write,
    input  logic [ARCH_SIZE:0] mem_write_data,
`endif
    output logic [ARCH_SIZE:0] mem_value,
    output logic             mem_ready,
    output logic             mem_fault
);
    import cpu_pkg::*;

    localparam int WIDTH = ARCH_SIZE + 1;
    localparam int IW    = $clog2(DEPTH);

    mem_state_t       state;
    logic [3:0]       count;
    logic [IW-1:0]    index;
    logic             in_range;
    logic             addr_in_range;
    logic             fire;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] fetch_value;

`ifdef INSTRUCTION_MEMORY_WRITE_EN
    logic             write_req;
    logic [WIDTH-1:0] write_data_q;
    logic             write_en;
`endif

    // Word index is address >> 1; every bit above the index field must be zero.
    assign addr_in_range = (mem_address >> (IW + 1)) == '0;
    assign fire          = (state == WAIT) && mem_read && (count == 4'd0);

`ifdef INSTRUCTION_MEMORY_WRITE_EN
    assign write_en = fire && write_req && in_range;
`endif

    mem_array #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .NOOP_LIMIT (NOOP_LIMIT)
    ) u_mem_array (
        .clock      (clock),
        .reset      (reset),
        .read_index (index),
        .read_data  (read_data)
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        ,
        .write_en    (write_en),
        .write_index (index),
        .write_data  (write_data_q)
`endif
    );

    always_comb begin
        fetch_value = in_range ? read_data : WIDTH'(HALT);
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        if (write_req) begin
            fetch_value = mem_value;
        end
`endif
    end

    // Even LATENCY = 1 spends one edge in WAIT so mem_ready always rises LATENCY edges after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            index     <= '0;
            in_range  <= 1'b0;
            mem_value <= '0;
            mem_ready <= 1'b0;
            mem_fault <= 1'b0;
`ifdef INSTRUCTION_MEMORY_WRITE_EN
            write_req    <= 1'b0;
            write_data_q <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_read) begin
                        index    <= mem_address[IW:1];
                        in_range <= addr_in_range;
                        count    <= 4'(LATENCY - 1);
`ifdef INSTRUCTION_MEMORY_WRITE_EN
                        write_req    <= mem_write;
                        write_data_q <= mem_write_data;
`endif
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_read) begin
                        state <= IDLE;
                    end else if (count == 4'd0) begin
                        mem_value <= fetch_value;
                        mem_fault <= !in_range;
                        mem_ready <= 1'b1;
                        state     <= READY;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                READY: begin
                    if (!mem_read) begin
                        mem_ready <= 1'b0;
                        mem_fault <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: driver pushes expected responses, monitor checks them.
module tb_instruction_memory;

    localparam int LATENCY    = 2;
    localparam int DEPTH      = 32;
    localparam int NOOP_LIMIT = 16;
    localparam int IW         = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address = 32'd0;
    logic        mem_read = 1'b0;
`ifdef INSTRUCTION_MEMORY_WRITE_EN
    logic        mem_write = 1'b0;
    logic [31:0] mem_write_data = 32'd0;
`endif
    logic [31:0] mem_value;
    logic        mem_ready;
    logic        mem_fault;

    always #5 clock = ~clock;

    instruction_memory #(
        .ARCH_SIZE  (31),
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY),
        .NOOP_LIMIT (NOOP_LIMIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_read    (mem_read),
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
`endif
        .mem_value   (mem_value),
        .mem_ready   (mem_ready),
        .mem_fault   (mem_fault)
    );

    typedef struct {
        logic [31:0] value;
        logic        fault;
        int          cycle;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_prev = 1'b0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_value;
    logic [31:0] r_addr;
    bit          r_wr;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = (2 * i <= NOOP_LIMIT) ? 32'd0 : 32'd1;
        end
        last_value = 32'd0;
    endtask

    task automatic model_req(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                             output logic [31:0] v, output logic f);
        logic [31:0] idx;
        bit          inr;
        idx = addr >> 1;
        inr = idx < DEPTH;
        f   = !inr;
        if (wr) begin
            v = last_value;
            if (inr) mdl[idx[IW-1:0]] = wd;
        end else begin
            v = inr ? mdl[idx[IW-1:0]] : 32'd1;
        end
        last_value = v;
    endtask

    task automatic push_expected(input logic [31:0] addr, input bit wr, input logic [31:0] wd);
        exp_t e;
        logic [31:0] v;
        logic f;
        model_req(addr, wr, wd, v, f);
        e.value = v;
        e.fault = f;
        e.cycle = cyc + 1 + LATENCY;
        sb.push_back(e);
    endtask

    task automatic start_req(input logic [31:0] addr, input bit wr, input logic [31:0] wd);
        @(negedge clock);
        mem_address = addr;
        mem_read    = 1'b1;
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        mem_write      = wr;
        mem_write_data = wd;
`endif
        push_expected(addr, wr, wd);
    endtask

    // Address wiggles while waiting; the DUT must have latched it already.
    task automatic wait_ready();
        int n;
        n = 0;
        while (mem_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            mem_address = $urandom;
            n++;
        end
        if (mem_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: mem_ready still %b after %0d cycles, expected 1", mem_ready, n);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic finish_req(input int hold, input int gap);
        wait_ready();
        repeat (hold) @(negedge clock);
        mem_read = 1'b0;
`ifdef INSTRUCTION_MEMORY_WRITE_EN
        mem_write = 1'b0;
`endif
        @(negedge clock);
        check_bit("ready_drop", mem_ready, 1'b0);
        check_bit("fault_drop", mem_fault, 1'b0);
        check_word("value_hold", mem_value, last_value);
        repeat (gap) @(negedge clock);
    endtask

    task automatic abort_req(input logic [31:0] addr);
        bit seen;
        @(negedge clock);
        mem_address = addr;
        mem_read    = 1'b1;
        @(negedge clock);
        mem_read    = 1'b0;
        mem_address = $urandom;
        seen = 1'b0;
        repeat (LATENCY + 3) begin
            @(negedge clock);
            if (mem_ready === 1'b1) seen = 1'b1;
        end
        check_bit("abort_no_ready", seen, 1'b0);
        check_word("abort_value", mem_value, last_value);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        mem_read = 1'b0;
        repeat (2) @(negedge clock);
        model_reset();
        check_bit("reset_ready", mem_ready, 1'b0);
        check_bit("reset_fault", mem_fault, 1'b0);
        check_word("reset_value", mem_value, 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: every rising mem_ready must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (mem_ready === 1'b1 && mon_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: mem_ready rose with value %0h, expected no response", mem_value);
                end else begin
                    mon_e = sb.pop_front();
                    check_word("resp_value", mem_value, mon_e.value);
                    check_bit("resp_fault", mem_fault, mon_e.fault);
                    check_word("resp_cycle", cyc, mon_e.cycle);
                end
            end
            mon_prev = mem_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check_bit("init_ready", mem_ready, 1'b0);
        check_bit("init_fault", mem_fault, 1'b0);
        check_word("init_value", mem_value, 32'd0);
        reset = 1'b0;

        start_req(32'd4, 1'b0, 32'd0);      finish_req(0, 0);
        start_req(32'd18, 1'b0, 32'd0);     finish_req(1, 0);
        start_req(32'h100, 1'b0, 32'd0);    finish_req(0, 1);
        start_req(32'd16, 1'b0, 32'd0);     finish_req(2, 0);
        start_req(32'd17, 1'b0, 32'd0);     finish_req(0, 0);
        start_req(32'd63, 1'b0, 32'd0);     finish_req(0, 0);
        start_req(32'd64, 1'b0, 32'd0);     finish_req(0, 0);
        start_req(32'h8000_0000, 1'b0, 32'd0); finish_req(0, 0);

        abort_req(32'd18);
        start_req(32'd6, 1'b0, 32'd0);      finish_req(0, 0);

        // Reset while READY with mem_read held high: request is served afresh afterwards.
        start_req(32'd18, 1'b0, 32'd0);
        wait_ready();
        reset = 1'b1;
        @(negedge clock);
        check_bit("rst_ready_ready", mem_ready, 1'b0);
        check_word("rst_ready_value", mem_value, 32'd0);
        model_reset();
        @(negedge clock);
        mem_address = 32'd18;
        push_expected(32'd18, 1'b0, 32'd0);
        reset = 1'b0;
        finish_req(1, 1);

        for (int a = 0; a <= 18; a += 2) begin
            start_req(a, 1'b0, 32'd0);
            finish_req(0, 0);
        end

`ifdef INSTRUCTION_MEMORY_WRITE_EN
        start_req(32'd2, 1'b1, 32'd1);      finish_req(0, 0);
        start_req(32'd2, 1'b0, 32'd0);      finish_req(0, 0);
        start_req(32'h200, 1'b1, 32'd5);   finish_req(0, 0);
        do_reset();
        start_req(32'd2, 1'b0, 32'd0);      finish_req(0, 0);
`endif

        for (int k = 0; k < 60; k++) begin
            r_addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h3ff)
                                                 : $urandom_range(0, 2 * DEPTH - 1);
            r_wr = 1'b0;
`ifdef INSTRUCTION_MEMORY_WRITE_EN
            r_wr = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 7) == 0) begin
                abort_req(r_addr);
            end else begin
                start_req(r_addr, r_wr, $urandom);
                finish_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end
            if (k == 30) do_reset();
        end

        repeat (LATENCY + 3) @(negedge clock);
        check_word("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
